// File: rtl/conv_8b_32b_pkg.sv
// Shared definitions for the 8b<->32b conversion path: widths, byte-index FSM states, lane parity.
package conv_8b_32b_pkg;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int OUT_BYTES_W    = 3;

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2,
    B3 = 2'd3
  } estado_byte_t;

  // Bit k is the even parity of physical byte lane k (bits [8k+7:8k]).
  function automatic logic [BYTES_PER_WORD-1:0] paridad_carriles(input logic [WORD_W-1:0] word);
    logic [BYTES_PER_WORD-1:0] par;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      par[k] = ^word[k*BYTE_W +: BYTE_W];
    end
    return par;
  endfunction
endpackage

// File: rtl/empaquetador_8b_32b_if.sv
// Byte-in / word-out handshake bundle for the 8b->32b packer.
// OUT_PAR exists only when EMPAQUETADOR_PARIDAD_EN is defined.
interface empaquetador_8b_32b_if;
  import conv_8b_32b_pkg::*;

  logic [BYTE_W-1:0]      IN_DATA;
  logic                   IN_VALID;
  logic                   IN_LAST;
  logic                   IN_READY;
  logic [WORD_W-1:0]      OUT_DATA;
  logic [OUT_BYTES_W-1:0] OUT_BYTES;
  logic                   OUT_VALID;
  logic                   OUT_READY;
`ifdef EMPAQUETADOR_PARIDAD_EN
  logic [BYTES_PER_WORD-1:0] OUT_PAR;

  modport slave (
    input  IN_DATA, IN_VALID, IN_LAST, OUT_READY,
    output IN_READY, OUT_DATA, OUT_BYTES, OUT_VALID, OUT_PAR
  );
  modport master (
    output IN_DATA, IN_VALID, IN_LAST, OUT_READY,
    input  IN_READY, OUT_DATA, OUT_BYTES, OUT_VALID, OUT_PAR
  );
`else
  modport slave (
    input  IN_DATA, IN_VALID, IN_LAST, OUT_READY,
    output IN_READY, OUT_DATA, OUT_BYTES, OUT_VALID
  );
  modport master (
    output IN_DATA, IN_VALID, IN_LAST, OUT_READY,
    input  IN_READY, OUT_DATA, OUT_BYTES, OUT_VALID
  );
`endif
endinterface

// File: rtl/registro_salida_32b.sv
// Single-entry output register: load on word close, clear on take, load wins over take.
// With EMPAQUETADOR_PARIDAD_EN defined, also registers per-lane even parity.
module registro_salida_32b
  import conv_8b_32b_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RESET_L,
  input  logic                   i_load,
  input  logic [WORD_W-1:0]      i_data,
  input  logic [OUT_BYTES_W-1:0] i_bytes,
  input  logic                   i_out_ready,
`ifdef EMPAQUETADOR_PARIDAD_EN
  output logic [BYTES_PER_WORD-1:0] o_par,
`endif
  output logic [WORD_W-1:0]      o_data,
  output logic [OUT_BYTES_W-1:0] o_bytes,
  output logic                   o_valid
);
  logic [WORD_W-1:0]      r_data;
  logic [OUT_BYTES_W-1:0] r_bytes;
  logic                   r_valid;

  // A load only happens when the upstream saw IN_READY, so it never clobbers an untaken word.
  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      r_data  <= '0;
      r_bytes <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_bytes <= i_bytes;
      r_valid <= 1'b1;
    end else if (i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef EMPAQUETADOR_PARIDAD_EN
  logic [BYTES_PER_WORD-1:0] r_par;

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      r_par <= '0;
    end else if (i_load) begin
      r_par <= paridad_carriles(i_data);
    end
  end

  assign o_par = r_par;
`endif

  assign o_data  = r_data;
  assign o_bytes = r_bytes;
  assign o_valid = r_valid;
endmodule

// File: rtl/empaquetador_8b_32b.sv
// 8-bit to 32-bit packer: byte-index FSM and accumulator feeding a single-entry output register.
// Optional per-lane parity output enabled by defining EMPAQUETADOR_PARIDAD_EN.
module empaquetador_8b_32b
  import conv_8b_32b_pkg::*;
#(
  parameter bit               MSB_FIRST = 1'b1,
  parameter logic [BYTE_W-1:0] PAD_BYTE  = 8'h00
) (
  input logic                 CLK,
  input logic                 RESET_L,
  empaquetador_8b_32b_if.slave bus
);
  estado_byte_t           r_state;
  estado_byte_t           w_state_next;
  logic [BYTE_W-1:0]      r_acc  [BYTES_PER_WORD];
  logic [BYTE_W-1:0]      w_lane [BYTES_PER_WORD];
  logic [WORD_W-1:0]      w_word;
  logic [OUT_BYTES_W-1:0] w_bytes;
  logic                   w_accept;
  logic                   w_close;
  logic                   w_in_ready;
  logic [WORD_W-1:0]      w_out_data;
  logic [OUT_BYTES_W-1:0] w_out_bytes;
  logic                   w_out_valid;

  assign w_in_ready = !w_out_valid || bus.OUT_READY;
  assign w_accept   = bus.IN_VALID && w_in_ready;
  assign w_bytes    = {1'b0, r_state} + 3'd1;

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      r_state <= B0;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_close      = 1'b0;
    if (w_accept) begin
      if (bus.IN_LAST || r_state == B3) begin
        w_close      = 1'b1;
        w_state_next = B0;
      end else begin
        case (r_state)
          B0:      w_state_next = B1;
          B1:      w_state_next = B2;
          B2:      w_state_next = B3;
          default: w_state_next = B0;
        endcase
      end
    end
  end

  // Logical lanes in arrival order: filled bytes, the current byte, then padding.
  always_comb begin
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      w_lane[k] = PAD_BYTE;
      if (k < int'(r_state)) begin
        w_lane[k] = r_acc[k];
      end else if (k == int'(r_state)) begin
        w_lane[k] = bus.IN_DATA;
      end
    end
  end

  always_comb begin
    w_word = '0;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (MSB_FIRST) begin
        w_word[(BYTES_PER_WORD-1-k)*BYTE_W +: BYTE_W] = w_lane[k];
      end else begin
        w_word[k*BYTE_W +: BYTE_W] = w_lane[k];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        r_acc[k] <= '0;
      end
    end else if (w_accept && !w_close) begin
      r_acc[r_state] <= bus.IN_DATA;
    end
  end

  registro_salida_32b u_registro_salida (
    .CLK         (CLK),
    .RESET_L     (RESET_L),
    .i_load      (w_close),
    .i_data      (w_word),
    .i_bytes     (w_bytes),
    .i_out_ready (bus.OUT_READY),
`ifdef EMPAQUETADOR_PARIDAD_EN
    .o_par       (bus.OUT_PAR),
`endif
    .o_data      (w_out_data),
    .o_bytes     (w_out_bytes),
    .o_valid     (w_out_valid)
  );

  assign bus.IN_READY  = w_in_ready;
  assign bus.OUT_DATA  = w_out_data;
  assign bus.OUT_BYTES = w_out_bytes;
  assign bus.OUT_VALID = w_out_valid;
endmodule
